wino_data_controller: RTL
=========================

// Module: wino_data_controller
// PURPOSE
//  Input-tile sequencer directly downstream of main_controller. For one input channel (data_id_i)
//  it walks block_height_i x block_width_i Winograd tiles (6x6 output each) and reads every tile
//  row from input SRAM. It streams the rows to the input-transform stage with valid/ready, then
//  pulses loop_finished_o back to main_controller. Kernel 3x3 (size_type_i=0) -> 8-row tile;
//  kernel 5x5 (size_type_i=1) -> 10-row tile.
// PARAMETERS
//  PIX_W      8    bits per pixel
//  TILE_MAX   10   max tile rows and pixels per SRAM word
//  MAX_H      64   input rows stored per channel, halo included
//  MAX_BW     16   max column blocks per row
//  ADDR_W     14   SRAM address width
//  FIFO_DEPTH 4    output skid FIFO entries, power of 2
// PORTS
//  clk              in   1                  clock
//  reset            in   1                  synchronous active-high reset
//  data_prepare_i   in   1                  main_controller requests a channel loop (level)
//  data_id_i        in   4                  input channel index
//  block_width_i    in   8                  column blocks, 0 treated as 1
//  block_height_i   in   8                  row blocks, 0 treated as 1
//  size_type_i      in   1                  0: 8-row tile, 1: 10-row tile
//  loop_finished_o  out  1                  1-cycle pulse, channel loop complete
//  sram_ren_o       out  1                  SRAM read enable
//  sram_addr_o      out  ADDR_W             ((id*MAX_H + y)*MAX_BW + bx), truncated to ADDR_W
//  sram_rdata_i     in   TILE_MAX*PIX_W     row word, valid exactly 1 cycle after sram_ren_o
//  tile_valid_o     out  1                  tile row available
//  tile_ready_i     in   1                  downstream accepts when valid&ready
//  tile_data_o      out  TILE_MAX*PIX_W     row pixels; pixel 0 in LSBs
//  tile_row_o       out  4                  row index in tile, 0..TILE-1
//  tile_last_o      out  1                  last row of the current tile
// BEHAVIOUR
//  Reset: state=IDLE, counters=0, FIFO empty. All outputs 0 (loop_finished_o, sram_ren_o,
//   sram_addr_o, tile_valid_o, tile_data_o, tile_row_o, tile_last_o).
//  Reset mid-operation aborts the loop. In-flight read data is discarded. No loop_finished_o pulse.
//  FSM: IDLE -> FETCH when data_prepare_i=1. In that cycle latch id, block dims and size_type;
//   later input changes are ignored until the next IDLE.
//   FETCH -> DRAIN after the read for the last row of the last tile is issued.
//   DRAIN -> DONE when the FIFO is empty and no read is in flight; loop_finished_o=1 for that one cycle.
//   DONE -> IDLE when data_prepare_i=0. This blocks a false restart while main_controller is
//   still in PREPARE.
//  Loop order, innermost first: r = 0..TILE-1, then bx = 0..BW-1, then by = 0..BH-1.
//   TILE = size_type ? 10 : 8. The row address uses y = by*6 + r. Memory is pre-padded with halo.
//  Read issue: sram_ren_o=1 in FETCH when fifo_count + inflight < FIFO_DEPTH (inflight is 0 or 1).
//   Data is pushed the next cycle along with its tagged r and last flag.
//   Sustained throughput is 1 row/clk while tile_ready_i=1.
//  Output: tile_* come from the FIFO head, and tile_valid_o = !empty. Pop on valid&ready. Push and
//   pop in the same cycle keep the count unchanged. The FIFO never overflows, by the credit rule.
//   Payload is held stable while valid&!ready.
//  Counter widths: by/bx are 8 bits, r is 4 bits. Address arithmetic is done at 16 bits, then truncated.
// STRUCTURE
//  Shared package wino_pkg: dc_state_t enum {IDLE,FETCH,DRAIN,DONE}, TILE_3X3=8, TILE_5X5=10,
//   OUT_TILE=6.
//  Sub-module data_skid_fifo, parameterised on width and depth: sync FIFO with count, push, pop,
//   synchronous clear.
//  Top level holds the FSM, the loop counters, the address generator and the inflight flag.
// TESTING
//  1 bw=1,bh=1,type0,id=0, ready=1 -> 8 reads at addr 0,16,...,112; 8 rows with tile_row 0..7;
//    last on row 7; one finished pulse.
//  2 bw=2,bh=2,type1,id=3 -> 40 rows. First addr=3*64*16=3072. bx steps +1, by steps +6*16.
//    Exactly 4 tile_last.
//  3 Case 1 with ready toggling 1/0 each cycle -> no row lost or duplicated, payload held while
//    stalled, no more than 4 rows buffered.
//  4 Hold data_prepare_i=1 for 5 cycles after the pulse -> stays in DONE, no new reads. Dropping
//    it, then raising it again, starts a new loop.
//  5 Assert reset after the 10th row accept of case 2 -> next cycle all outputs 0, no finished
//    pulse, a fresh loop completes normally.
//  6 bw=0,bh=0 -> treated as 1x1, identical to case 1.

Source files
------------

// File: rtl/wino_pkg.sv
// Shared types and constants for the Winograd input-tile data path.
package wino_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } dc_state_t;

    localparam int TILE_3X3 = 8;
    localparam int TILE_5X5 = 10;
    localparam int OUT_TILE = 6;

    // Rows per input tile for the selected kernel size.
    function automatic logic [3:0] tile_rows(input logic size_type);
        return size_type ? 4'(TILE_5X5) : 4'(TILE_3X3);
    endfunction

endpackage

// File: rtl/data_skid_fifo.sv
// Synchronous FIFO with occupancy count and synchronous clear; head word is always on rdata.
module data_skid_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign do_push = push && (count_q != CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/wino_data_controller.sv
// Walks the Winograd input tiles of one channel, reads each tile row from SRAM and streams it out.
// Streams: a beat transfers on a clock edge where valid&ready; while valid&!ready the payload holds.
module wino_data_controller
    import wino_pkg::*;
#(
    parameter int PIX_W      = 8,
    parameter int TILE_MAX   = 10,
    parameter int MAX_H      = 64,
    parameter int MAX_BW     = 16,
    parameter int ADDR_W     = 14,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      data_prepare_i,
    input  logic [3:0]                data_id_i,
    input  logic [7:0]                block_width_i,
    input  logic [7:0]                block_height_i,
    input  logic                      size_type_i,
    output logic                      loop_finished_o,
    output logic                      sram_ren_o,
    output logic [ADDR_W-1:0]         sram_addr_o,
    input  logic [TILE_MAX*PIX_W-1:0] sram_rdata_i,
    output logic                      tile_valid_o,
    input  logic                      tile_ready_i,
    output logic [TILE_MAX*PIX_W-1:0] tile_data_o,
    output logic [3:0]                tile_row_o,
    output logic                      tile_last_o,
    output dc_state_t                 dbg_state
);

    localparam int DATA_W = TILE_MAX * PIX_W;
    localparam int ENTRY_W = DATA_W + 5;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    dc_state_t state, state_next;
    logic [3:0]  id_q;
    logic [7:0]  bw_q, bh_q;
    logic        size_q;
    logic [3:0]  r_q;
    logic [7:0]  bx_q, by_q;
    logic        inflight_q, inflight_last_q;
    logic [3:0]  inflight_row_q;

    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_head;
    logic [CNT_W:0]     occupancy;
    logic               issue, last_row, last_bx, last_by;
    logic [15:0]        row_y, addr16;

    assign last_row = (r_q == tile_rows(size_q) - 4'd1);
    assign last_bx  = (bx_q == bw_q - 8'd1);
    assign last_by  = (by_q == bh_q - 8'd1);

    // A read may only be issued if its data is guaranteed a FIFO slot on return.
    assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    assign issue     = (state == FETCH) && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));

    assign row_y  = 16'(by_q) * 16'(OUT_TILE) + 16'(r_q);
    assign addr16 = (16'(id_q) * 16'(MAX_H) + row_y) * 16'(MAX_BW) + 16'(bx_q);

    assign sram_ren_o  = issue;
    assign sram_addr_o = issue ? ADDR_W'(addr16) : '0;
    assign dbg_state   = state;

    always_comb begin
        state_next      = state;
        loop_finished_o = 1'b0;
        case (state)
            IDLE:  if (data_prepare_i) state_next = FETCH;
            FETCH: if (issue && last_row && last_bx && last_by) state_next = DRAIN;
            DRAIN: begin
                if (fifo_empty && !inflight_q) begin
                    state_next      = DONE;
                    loop_finished_o = 1'b1;
                end
            end
            // Wait for the request to drop so a lingering request does not restart the loop.
            DONE:  if (!data_prepare_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            id_q            <= '0;
            bw_q            <= '0;
            bh_q            <= '0;
            size_q          <= 1'b0;
            r_q             <= '0;
            bx_q            <= '0;
            by_q            <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            inflight_row_q  <= '0;
        end else begin
            state           <= state_next;
            inflight_q      <= issue;
            inflight_last_q <= last_row;
            inflight_row_q  <= r_q;
            if (state == IDLE && data_prepare_i) begin
                id_q   <= data_id_i;
                bw_q   <= (block_width_i == 8'd0) ? 8'd1 : block_width_i;
                bh_q   <= (block_height_i == 8'd0) ? 8'd1 : block_height_i;
                size_q <= size_type_i;
                r_q    <= '0;
                bx_q   <= '0;
                by_q   <= '0;
            end else if (issue) begin
                if (!last_row) begin
                    r_q <= r_q + 4'd1;
                end else begin
                    r_q <= '0;
                    if (!last_bx) begin
                        bx_q <= bx_q + 8'd1;
                    end else begin
                        bx_q <= '0;
                        by_q <= by_q + 8'd1;
                    end
                end
            end
        end
    end

    data_skid_fifo #(
        .WIDTH(ENTRY_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .clear (reset),
        .push  (inflight_q),
        .wdata ({sram_rdata_i, inflight_row_q, inflight_last_q}),
        .pop   (tile_valid_o && tile_ready_i),
        .rdata (fifo_head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign tile_valid_o = !fifo_empty;
    assign tile_data_o  = fifo_empty ? '0 : fifo_head[ENTRY_W-1:5];
    assign tile_row_o   = fifo_empty ? '0 : fifo_head[4:1];
    assign tile_last_o  = fifo_empty ? 1'b0 : fifo_head[0];

endmodule
